// File: rtl/stand_delay_mc.sv
// Multi-channel stall-injection delay generator: each channel runs an independent
// delay_start/delay_done handshake whose delay comes from a per-channel 32-bit Galois LFSR.
module stand_delay_mc #(
    parameter int          CH              = 4,
    parameter int          DELAY_MAX_PTR   = 5,
    parameter int          DELAY_MIN       = 0,
    parameter int          DELAY_FIXED     = 3,
    parameter int          DELAY_START_EN  = 1,
    parameter int          DELAY_START_CNT = 10,
    parameter logic [31:0] DELAY_SEED      = 32'h1d76993a
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [2*CH-1:0]   delay_mode,
    input  logic [CH-1:0]     delay_high,
    input  logic [CH-1:0]     delay_freeze,
    input  logic [CH-1:0]     delay_start,
    output logic [CH-1:0]     delay_done,
    output logic [16*CH-1:0]  hs_cnt
);

    localparam int              CNT_W    = DELAY_MAX_PTR + 3;
    localparam logic [31:0]     LFSR_TAP = 32'h80200003;
    localparam logic [CNT_W-1:0] CNT_RST = (DELAY_START_EN != 0) ? CNT_W'(DELAY_START_CNT) : '0;
    localparam logic [CNT_W-1:0] D_MIN   = CNT_W'(DELAY_MIN);
    localparam logic [CNT_W-1:0] D_FIXED = CNT_W'(DELAY_FIXED);

    typedef enum logic [1:0] {
        MODE_FIXED   = 2'd0,
        MODE_UNIFORM = 2'd1,
        MODE_BIMODAL = 2'd2,
        MODE_PASS    = 2'd3
    } mode_e;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        localparam logic [31:0] SEED_X = DELAY_SEED ^ 32'(i);
        localparam logic [31:0] SEED_I = (SEED_X == 32'h0) ? 32'h1 : SEED_X;

        logic [CNT_W-1:0] r_cnt;
        logic [31:0]      r_lfsr;
        logic [15:0]      r_hs;
        logic [CNT_W-1:0] w_r;
        logic [CNT_W-1:0] w_lo;
        logic [CNT_W-1:0] w_d;
        logic [31:0]      w_lfsr_next;
        logic             w_hs;
        mode_e            w_mode;

        assign w_mode        = mode_e'(delay_mode[2*i +: 2]);
        assign delay_done[i] = (r_cnt == '0) & ~delay_freeze[i];
        assign w_hs          = delay_done[i] & delay_start[i];
        assign w_lfsr_next   = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAP : 32'h0);
        assign hs_cnt[16*i +: 16] = r_hs;

        // D is taken from the pre-advance LFSR; mode/high only matter in the handshake cycle.
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        always_comb begin
            w_r = '0;
            if (delay_high[i]) w_r = r_lfsr[CNT_W-1:0];
            else               w_r[DELAY_MAX_PTR-1:0] = r_lfsr[DELAY_MAX_PTR-1:0];
            w_lo = (w_r < D_MIN) ? D_MIN : w_r;
            w_d  = '0;
            case (w_mode)
                MODE_FIXED:   w_d = D_FIXED;
                MODE_UNIFORM: w_d = w_lo;
                MODE_BIMODAL: w_d = r_lfsr[31] ? w_lo : '0;
                MODE_PASS:    w_d = '0;
                default:      w_d = '0;
            endcase
        end

        // NOTE: state registers use non-blocking assignments so all channels update from pre-edge values.
        always_ff @(posedge clk) begin
            if (!rst_) begin
                r_cnt  <= CNT_RST;
                r_lfsr <= SEED_I;
                r_hs   <= '0;
            end else if (w_hs) begin
                r_cnt  <= w_d;
                r_lfsr <= w_lfsr_next;
                r_hs   <= (r_hs == 16'hFFFF) ? r_hs : r_hs + 16'd1;
            end else if (r_cnt != '0 && !delay_freeze[i]) begin
                r_cnt  <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stand_delay_mc.sv
// Scoreboard bench for stand_delay_mc: a behavioural model predicts each handshake's delay
// and hs_cnt; a monitor measures done-low runs on the DUT and compares.
`timescale 1ns/1ps
module tb_stand_delay_mc;

    localparam int          CH        = 4;
    localparam int          PTR       = 5;
    localparam int          MIN       = 4;
    localparam int          FIXED     = 3;
    localparam int          START_CNT = 10;
    localparam logic [31:0] SEED      = 32'h1d76993a;
    localparam logic [31:0] POLY      = 32'h80200003;

    logic              clk = 1'b0;
    logic              rst_ = 1'b0;
    logic [2*CH-1:0]   delay_mode = '0;
    logic [CH-1:0]     delay_high = '0;
    logic [CH-1:0]     delay_freeze = '0;
    logic [CH-1:0]     delay_start = '0;
    logic [CH-1:0]     delay_done;
    logic [16*CH-1:0]  hs_cnt;

    stand_delay_mc #(
        .CH(CH), .DELAY_MAX_PTR(PTR), .DELAY_MIN(MIN), .DELAY_FIXED(FIXED),
        .DELAY_START_EN(1), .DELAY_START_CNT(START_CNT), .DELAY_SEED(SEED)
    ) dut (
        .clk(clk), .rst_(rst_), .delay_mode(delay_mode), .delay_high(delay_high),
        .delay_freeze(delay_freeze), .delay_start(delay_start),
        .delay_done(delay_done), .hs_cnt(hs_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int d;
        int hs;
        int mode;
        bit high;
    } exp_t;

    exp_t        exp_q[CH][$];
    int          m_rem[CH];
    logic [31:0] m_lfsr[CH];
    int          m_hs[CH];

    function automatic logic [31:0] seed_of(input int c);
        logic [31:0] s = SEED ^ 32'(c);
        return (s == 0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? POLY : 32'h0);
    endfunction

    function automatic int calc_d(input logic [31:0] v, input int mode, input bit high);
        int span = high ? (1 << (PTR + 3)) : (1 << PTR);
        int r    = int'(v % 32'(span));
        int lo   = (r < MIN) ? MIN : r;
        case (mode)
            0:       return FIXED;
            1:       return lo;
            2:       return v[31] ? lo : 0;
            default: return 0;
        endcase
    endfunction

    // Inputs are stable at the falling edge, so the model predicts the coming rising edge here.
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (!rst_) begin
                m_rem[c]  = START_CNT;
                m_lfsr[c] = seed_of(c);
                m_hs[c]   = 0;
                exp_q[c].delete();
            end else if (m_rem[c] == 0 && !delay_freeze[c] && delay_start[c]) begin
                exp_t e;
                e.mode = int'(delay_mode[2*c +: 2]);
                e.high = delay_high[c];
                e.d    = calc_d(m_lfsr[c], e.mode, e.high);
                m_hs[c] = (m_hs[c] >= 16'hFFFF) ? 16'hFFFF : m_hs[c] + 1;
                e.hs   = m_hs[c];
                exp_q[c].push_back(e);
                m_rem[c]  = e.d;
                m_lfsr[c] = lfsr_step(m_lfsr[c]);
            end else if (m_rem[c] != 0 && !delay_freeze[c]) begin
                m_rem[c]--;
            end
        end
    end

    // ---------------- monitor ----------------
    bit   pend[CH];
    bit   busy[CH];
    int   meas[CH];
    exp_t cur[CH];
    int   zero_seen = 0;

    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (!rst_) begin
                pend[c] = 0;
                busy[c] = 0;
            end else begin
                if (pend[c]) begin
                    pend[c] = 0;
                    if (exp_q[c].size() == 0) begin
                        check($sformatf("unexpected_handshake_ch%0d", c), 1, 0);
                    end else begin
                        cur[c] = exp_q[c].pop_front();
                        check($sformatf("hs_cnt_ch%0d", c), hs_cnt[16*c +: 16], cur[c].hs);
                        busy[c] = 1;
                        meas[c] = 0;
                    end
                end
                if (busy[c]) begin
                    if (delay_done[c]) begin
                        busy[c] = 0;
                        check($sformatf("delay_len_ch%0d", c), meas[c], cur[c].d);
                        if (cur[c].mode == 1 || (cur[c].mode == 2 && meas[c] != 0))
                            check($sformatf("delay_range_ch%0d", c),
                                  (meas[c] >= MIN) && (meas[c] < (cur[c].high ? 256 : 32)), 1);
                        if (cur[c].mode == 2 && meas[c] == 0) zero_seen++;
                    end else if (!delay_freeze[c]) begin
                        meas[c]++;
                    end
                end
                if (delay_done[c] && delay_start[c]) pend[c] = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
    endtask

    task automatic startup_check();
        for (int i = 0; i <= START_CNT; i++) begin
            @(negedge clk);
            check($sformatf("startup_done_cyc%0d", i), delay_done, (i == START_CNT) ? {CH{1'b1}} : {CH{1'b0}});
            if (i == 0) check("startup_hs_cnt", hs_cnt, 64'h0);
            tick();
        end
    endtask

    task automatic rand_cycles(input int n, input bit with_freeze);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < CH; c++) begin
                delay_mode[2*c +: 2] = 2'($urandom_range(1, 2));
                delay_high[c]        = 1'($urandom_range(0, 1));
                delay_start[c]       = ($urandom_range(0, 3) != 0);
                delay_freeze[c]      = with_freeze && ($urandom_range(0, 9) == 0);
            end
            tick();
        end
    endtask

    task automatic drain();
        delay_start  = '0;
        delay_freeze = '0;
        repeat (300) tick();
    endtask

    initial begin
        int low;
        int hs_hold;

        // Reset and start-up delay.
        tick();
        do_reset();
        startup_check();

        // Fixed mode with start held: done 1,0,0,0 repeating.
        delay_mode  = '0;
        delay_start = '1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            check($sformatf("fixed_done_cyc%0d", j), delay_done, (j % 4 == 0) ? {CH{1'b1}} : {CH{1'b0}});
            tick();
        end
        @(negedge clk);
        check("fixed_hs_cnt_ch0", hs_cnt[15:0], 16'd3);
        drain();

        // Random modes 1/2, random range, random freeze.
        rand_cycles(800, 1'b1);
        drain();

        // Freeze during a fixed delay of 3: one decrement, then 5 frozen cycles.
        delay_mode     = '0;
        delay_start[0] = 1'b1;
        tick();
        delay_start[0] = 1'b0;
        low = 0;
        for (int j = 1; j <= 12; j++) begin
            delay_freeze[0] = (j >= 2 && j <= 6);
            @(negedge clk);
            if (!delay_done[0]) low++;
            tick();
        end
        delay_freeze[0] = 1'b0;
        check("freeze_low_cycles", low, 8);

        // Freeze while idle: start must be ignored.
        tick();
        hs_hold         = m_hs[0];
        delay_freeze[0] = 1'b1;
        delay_start[0]  = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("freeze_idle_done", delay_done[0], 1'b0);
            tick();
        end
        check("freeze_idle_hs", hs_cnt[15:0], hs_hold);
        drain();

        // Reset in the middle of random counting, then replay from the seed.
        rand_cycles(15, 1'b0);
        delay_start = '0;
        do_reset();
        startup_check();
        rand_cycles(500, 1'b0);
        drain();

        // Pass mode: back-to-back handshakes until hs_cnt saturates.
        delay_mode  = '1;
        delay_start = '1;
        repeat (65540) tick();
        @(negedge clk);
        check("pass_done", delay_done, {CH{1'b1}});
        check("sat_hs_cnt", hs_cnt, {CH{16'hFFFF}});
        drain();

        for (int c = 0; c < CH; c++) begin
            check($sformatf("queue_empty_ch%0d", c), exp_q[c].size(), 0);
            check($sformatf("monitor_idle_ch%0d", c), busy[c] | pend[c], 1'b0);
        end
        check("mode2_zero_seen", zero_seen > 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_500_000;
        errors++;
        checks++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
